cdc_sample_fifo: RTL and testbench

Parametrised dual-clock FIFO that carries audio samples from the 100 MHz MicroBlaze domain (aClk) to the 18.432 MHz I2S domain (bClk). It replaces the single-word full/taken handshake with a Gray-pointer FIFO of configurable width and depth, so software can queue several samples ahead of the I2S transmitter. It adds first-word-fall-through read and sticky overflow/underflow flags.

---
 rtl/cdc_sample_fifo_if.sv | 40 ++++
 rtl/cdc_sample_fifo.sv | 170 +++++++++++++++++
 tb/tb_cdc_sample_fifo.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_sample_fifo_if.sv
// cdc_sample_fifo_if: handshake bundle between a sample producer (aClk side)
// and consumer (bClk side) and the dual-clock sample FIFO.
//   master : drives aWrite/aData/bRead, observes status, bData and flags
//   slave  : the FIFO itself
//   CDC_FIFO_LEVEL_EN adds ADDR_W and the aLevel/bLevel occupancy signals.
interface cdc_sample_fifo_if #(
    parameter int DATA_W = 24
`ifdef CDC_FIFO_LEVEL_EN
    , parameter int ADDR_W = 3
`endif
);
    logic              aWrite;
    logic [DATA_W-1:0] aData;
    logic              aFull;
    logic              aOverflow;
    logic              bRead;
    logic [DATA_W-1:0] bData;
    logic              bValid;
    logic              bUnderflow;
`ifdef CDC_FIFO_LEVEL_EN
    logic [ADDR_W:0]   aLevel;
    logic [ADDR_W:0]   bLevel;
`endif

    modport master (
        output aWrite, aData, bRead,
        input  aFull, aOverflow, bData, bValid, bUnderflow
`ifdef CDC_FIFO_LEVEL_EN
        , input aLevel, bLevel
`endif
    );

    modport slave (
        input  aWrite, aData, bRead,
        output aFull, aOverflow, bData, bValid, bUnderflow
`ifdef CDC_FIFO_LEVEL_EN
        , output aLevel, bLevel
`endif
    );
endinterface

// File: rtl/cdc_sample_fifo.sv
// cdc_sample_fifo: Gray-pointer dual-clock FIFO carrying audio samples from the
// aClk (CPU) domain to the bClk (I2S) domain, first-word-fall-through read.
// Ports:
//   aClk/aResetn : write clock, async active-low reset
//   bClk/bResetn : read clock, async active-low reset
//   bus (slave)  : aWrite/aData push, aFull, sticky aOverflow,
//                  bRead pop, bData head, bValid, sticky bUnderflow
// Optional: define CDC_FIFO_LEVEL_EN for registered aLevel/bLevel occupancy.
module cdc_sample_fifo #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 3
) (
    input  logic             aClk,
    input  logic             aResetn,
    input  logic             bClk,
    input  logic             bResetn,
    cdc_sample_fifo_if.slave bus
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    // Full when the write Gray pointer equals the read Gray pointer with
    // its two top bits inverted (one lap ahead).
    localparam logic [PTR_W-1:0] FULL_XOR = PTR_W'(3) << (ADDR_W - 1);

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

`ifdef CDC_FIFO_LEVEL_EN
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        for (int i = 0; i < PTR_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction
`endif

    // ---------------------------------------------------------------
    // Storage: written on aClk, read combinationally by the b side
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    // ---------------------------------------------------------------
    // Write (aClk) domain
    // ---------------------------------------------------------------
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] wgray_q, wgray_d;
    logic [PTR_W-1:0] rgray_sync1_q, rgray_sync2_q;
    logic             afull_q, afull_d;
    logic             aovf_q, aovf_d;
    logic             push;

    // Read-domain Gray pointer, only crossing signal into aClk
    logic [PTR_W-1:0] rgray_q;

    always_comb begin
        push    = bus.aWrite && !afull_q;
        wptr_d  = wptr_q + PTR_W'(push);
        wgray_d = bin2gray(wptr_d);
        afull_d = (wgray_d == (rgray_sync2_q ^ FULL_XOR));
        aovf_d  = aovf_q | (bus.aWrite & afull_q);
    end

    always_ff @(posedge aClk or negedge aResetn) begin
        if (!aResetn) begin
            wptr_q        <= '0;
            wgray_q       <= '0;
            rgray_sync1_q <= '0;
            rgray_sync2_q <= '0;
            afull_q       <= 1'b0;
            aovf_q        <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            wgray_q       <= wgray_d;
            rgray_sync1_q <= rgray_q;
            rgray_sync2_q <= rgray_sync1_q;
            afull_q       <= afull_d;
            aovf_q        <= aovf_d;
        end
    end

    // Memory is deliberately not reset
    always_ff @(posedge aClk) begin
        if (push) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= bus.aData;
        end
    end

    // ---------------------------------------------------------------
    // Read (bClk) domain
    // ---------------------------------------------------------------
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] rgray_d;
    logic [PTR_W-1:0] wgray_sync1_q, wgray_sync2_q;
    logic             bvalid_q, bvalid_d;
    logic             bunf_q, bunf_d;
    logic             pop;

    always_comb begin
        pop      = bus.bRead && bvalid_q;
        rptr_d   = rptr_q + PTR_W'(pop);
        rgray_d  = bin2gray(rptr_d);
        bvalid_d = (rgray_d != wgray_sync2_q);
        bunf_d   = bunf_q | (bus.bRead & ~bvalid_q);
    end

    always_ff @(posedge bClk or negedge bResetn) begin
        if (!bResetn) begin
            rptr_q        <= '0;
            rgray_q       <= '0;
            wgray_sync1_q <= '0;
            wgray_sync2_q <= '0;
            bvalid_q      <= 1'b0;
            bunf_q        <= 1'b0;
        end else begin
            rptr_q        <= rptr_d;
            rgray_q       <= rgray_d;
            wgray_sync1_q <= wgray_q;
            wgray_sync2_q <= wgray_sync1_q;
            bvalid_q      <= bvalid_d;
            bunf_q        <= bunf_d;
        end
    end

    // ---------------------------------------------------------------
    // Optional occupancy counters, registered alongside the flags
    // ---------------------------------------------------------------
`ifdef CDC_FIFO_LEVEL_EN
    logic [PTR_W-1:0] alevel_q, alevel_d;
    logic [PTR_W-1:0] blevel_q, blevel_d;

    always_comb begin
        alevel_d = wptr_d - gray2bin(rgray_sync2_q);
        blevel_d = gray2bin(wgray_sync2_q) - rptr_d;
    end

    always_ff @(posedge aClk or negedge aResetn) begin
        if (!aResetn) begin
            alevel_q <= '0;
        end else begin
            alevel_q <= alevel_d;
        end
    end

    always_ff @(posedge bClk or negedge bResetn) begin
        if (!bResetn) begin
            blevel_q <= '0;
        end else begin
            blevel_q <= blevel_d;
        end
    end

    assign bus.aLevel = alevel_q;
    assign bus.bLevel = blevel_q;
`endif

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.aFull      = afull_q;
    assign bus.aOverflow  = aovf_q;
    assign bus.bValid     = bvalid_q;
    assign bus.bUnderflow = bunf_q;
    // First-word-fall-through: head entry always presented
    assign bus.bData      = mem_q[rptr_q[ADDR_W-1:0]];

endmodule

// File: tb/tb_cdc_sample_fifo.sv
// tb_cdc_sample_fifo: self-checking bench for cdc_sample_fifo, scoreboard of
// accepted pushes compared against popped head entries.
module tb_cdc_sample_fifo;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic aClk    = 1'b0;
    logic bClk    = 1'b0;
    logic aResetn = 1'b0;
    logic bResetn = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] exp_q [$];

`ifdef CDC_FIFO_LEVEL_EN
    cdc_sample_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
`else
    cdc_sample_fifo_if #(.DATA_W(DATA_W)) bus ();
`endif

    cdc_sample_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .aClk    (aClk),
        .aResetn (aResetn),
        .bClk    (bClk),
        .bResetn (bResetn),
        .bus     (bus)
    );

    // aClk posedges at even ns, bClk posedges at odd ns: never coincident
    initial begin
        #1;
        forever #5 aClk = ~aClk;
    end

    initial begin
        forever #27 bClk = ~bClk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        bus.aWrite = 1'b0;
        bus.aData  = '0;
        bus.bRead  = 1'b0;
        aResetn    = 1'b0;
        bResetn    = 1'b0;
        repeat (3) @(posedge bClk);
        @(negedge aClk) aResetn = 1'b1;
        @(negedge bClk) bResetn = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge bClk);
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        @(negedge aClk);
        bus.aWrite = 1'b1;
        bus.aData  = d;
        @(posedge aClk);
        #1;
        bus.aWrite = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        int n;
        n = 0;
        @(negedge bClk);
        while (!bus.bValid && n < 20) begin
            @(negedge bClk);
            n++;
        end
        chk({tag, "_vld"}, 32'(bus.bValid), 32'd1);
        if (bus.bValid) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_extra"}, 32'd1, 32'd0);
            end else begin
                chk(tag, 32'(bus.bData), 32'(exp_q.pop_front()));
            end
            bus.bRead = 1'b1;
            @(posedge bClk);
            #1;
            bus.bRead = 1'b0;
        end
    endtask

    initial begin
        logic        wdone;
        logic        saw_full;
        logic [DATA_W-1:0] d;

        // ---- reset state ----
        do_reset();
        chk("rst_afull", 32'(bus.aFull), 32'd0);
        chk("rst_bvalid", 32'(bus.bValid), 32'd0);
        chk("rst_aovf", 32'(bus.aOverflow), 32'd0);
        chk("rst_bunf", 32'(bus.bUnderflow), 32'd0);
`ifdef CDC_FIFO_LEVEL_EN
        chk("rst_alevel", 32'(bus.aLevel), 32'd0);
        chk("rst_blevel", 32'(bus.bLevel), 32'd0);
`endif

        // ---- underflow on empty, then single push ----
        @(negedge bClk);
        bus.bRead = 1'b1;
        @(posedge bClk);
        #1;
        bus.bRead = 1'b0;
        chk("unf_flag", 32'(bus.bUnderflow), 32'd1);
        chk("unf_bvalid", 32'(bus.bValid), 32'd0);
        push(24'h123456);
        exp_q.push_back(24'h123456);
        for (int n = 0; n < 4; n++) begin
            @(posedge bClk);
            #1;
            if (bus.bValid) break;
        end
        chk("one_bvalid", 32'(bus.bValid), 32'd1);
        chk("one_bdata", 32'(bus.bData), 32'h123456);
        pop_chk("one_pop");
        repeat (2) @(negedge bClk);
        chk("one_empty", 32'(bus.bValid), 32'd0);
        chk("unf_sticky", 32'(bus.bUnderflow), 32'd1);

        // ---- fill to full, overflow drop ----
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            push(DATA_W'(i));
            exp_q.push_back(DATA_W'(i));
            chk($sformatf("fill_full%0d", i), 32'(bus.aFull),
                32'(i == DEPTH));
        end
        push(24'hABCDEF);
        chk("ovf_flag", 32'(bus.aOverflow), 32'd1);
        chk("ovf_full", 32'(bus.aFull), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            pop_chk($sformatf("fill_pop%0d", i));
        end
        repeat (4) @(negedge bClk);
        chk("fill_drained", 32'(bus.bValid), 32'd0);
        chk("fill_afull_clr", 32'(bus.aFull), 32'd0);
        chk("ovf_sticky", 32'(bus.aOverflow), 32'd1);

        // ---- wrap: 3 laps of the pointer space, one entry at a time ----
        do_reset();
        for (int i = 0; i < 3 * 2 * DEPTH; i++) begin
            d = DATA_W'($urandom);
            push(d);
            exp_q.push_back(d);
            chk("wrap_nofull", 32'(bus.aFull), 32'd0);
            pop_chk("wrap_data");
        end
        repeat (4) @(negedge bClk);
        chk("wrap_empty", 32'(bus.bValid), 32'd0);

        // ---- reset mid-stream with entries queued ----
        @(negedge bClk);
        bus.bRead = 1'b1;
        @(posedge bClk);
        #1;
        bus.bRead = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(24'h500000 + DATA_W'(i));
        end
        repeat (5) @(negedge bClk);
        chk("mid_pre_bvalid", 32'(bus.bValid), 32'd1);
        aResetn = 1'b0;
        bResetn = 1'b0;
        #1;
        chk("mid_afull", 32'(bus.aFull), 32'd0);
        chk("mid_bvalid", 32'(bus.bValid), 32'd0);
        chk("mid_bunf", 32'(bus.bUnderflow), 32'd0);
        chk("mid_aovf", 32'(bus.aOverflow), 32'd0);
        do_reset();
        chk("mid_post_bvalid", 32'(bus.bValid), 32'd0);
        push(24'h777777);
        exp_q.push_back(24'h777777);
        pop_chk("mid_first");

`ifdef CDC_FIFO_LEVEL_EN
        // ---- occupancy counters ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(DATA_W'(i + 32));
            exp_q.push_back(DATA_W'(i + 32));
        end
        repeat (4) @(posedge bClk);
        #1;
        chk("lvl_a5", 32'(bus.aLevel), 32'd5);
        chk("lvl_b5", 32'(bus.bLevel), 32'd5);
        pop_chk("lvl_pop1");
        pop_chk("lvl_pop2");
        chk("lvl_b3", 32'(bus.bLevel), 32'd3);
        repeat (4) @(posedge aClk);
        #1;
        chk("lvl_a3", 32'(bus.aLevel), 32'd3);
        for (int i = 0; i < 3; i++) begin
            pop_chk("lvl_drain");
        end
`endif

        // ---- continuous push at aClk vs continuous pop at bClk ----
        do_reset();
        wdone    = 1'b0;
        saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    @(negedge aClk);
                    bus.aWrite = 1'b1;
                    bus.aData  = DATA_W'($urandom);
                    if (!bus.aFull) begin
                        chk("rnd_room", 32'(exp_q.size() < DEPTH), 32'd1);
                        exp_q.push_back(bus.aData);
                    end else begin
                        saw_full = 1'b1;
                    end
                end
                @(negedge aClk);
                bus.aWrite = 1'b0;
                wdone = 1'b1;
            end
            begin
                bus.bRead = 1'b1;
                for (int c = 0; c < 6000; c++) begin
                    @(negedge bClk);
                    if (wdone && exp_q.size() == 0) break;
                    if (bus.bValid) begin
                        if (exp_q.size() == 0) begin
                            chk("rnd_extra", 32'd1, 32'd0);
                        end else begin
                            chk("rnd_data", 32'(bus.bData),
                                32'(exp_q.pop_front()));
                        end
                    end
                end
                bus.bRead = 1'b0;
            end
        join
        chk("rnd_drain", 32'(exp_q.size()), 32'd0);
        chk("rnd_ovf", 32'(bus.aOverflow), 32'(saw_full));
        repeat (6) @(negedge bClk);
        chk("rnd_end_empty", 32'(bus.bValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
